// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg
//   Shared types and constants for the VGA / CPU frame-buffer SRAM arbiter.
//   arb_state_t : owner of the current SRAM bus cycle
//   H_ACTIVE / V_ACTIVE : visible area, V_SWAP_LINE : first blanking line
package vga_arb_pkg;

  localparam int DATA_W = 16;

  localparam logic [9:0] H_ACTIVE    = 10'd640;
  localparam logic [9:0] V_ACTIVE    = 10'd480;
  localparam logic [9:0] V_SWAP_LINE = 10'd480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    CPU_RD  = 2'd2,
    CPU_WR  = 2'd3
  } arb_state_t;

  function automatic logic is_cpu(input arb_state_t s);
    return (s == CPU_RD) || (s == CPU_WR);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen
//   Frame-buffer word address: base + y*640 + x, built from shifts and adds
//   (y*640 = (y<<9) + (y<<7)). Result wraps to ADDR_W bits.
// Ports
//   base  in  ADDR_W  word base of the frame buffer being scanned
//   x     in  10      pixel column
//   y     in  10      pixel line
//   addr  out ADDR_W  SRAM word address
module fb_addr_gen #(
  parameter int ADDR_W = 20
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] x_w;
  logic [ADDR_W-1:0] y_w;

  assign x_w  = ADDR_W'(x);
  assign y_w  = ADDR_W'(y);
  assign addr = (y_w << 9) + (y_w << 7) + x_w + base;

endmodule

// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter
//   Shares one async 16-bit SRAM between VGA scan-out and a CPU port, and
//   double-buffers the frame (buffer swap applied at the start of vblank).
// Ports
//   Clk, Reset_n                  clock, synchronous active-low reset
//   pix_ce, DrawX, DrawY          VGA timing inputs
//   pix_data                      pixel for the coordinate of the previous pix_ce
//   cpu_req/we/addr/wdata         CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata            one-Clk completion pulse, read data
//   swap_req, fb_sel, swap_done   frame-buffer swap control/status
//   sram_*                        registered SRAM pin drive, sram_dq_in read data
//
// state   | meaning (owner of the current bus cycle)
// --------+------------------------------------------------
// IDLE    | bus parked, all strobes high, address held
// DISP_RD | scan-out read of the pixel at DrawX/DrawY
// CPU_RD  | CPU read, data captured at end of cycle
// CPU_WR  | CPU write, pad driven for the whole cycle
module vga_sram_arbiter
  import vga_arb_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] FB0_BASE = '0,
  parameter logic [ADDR_W-1:0] FB1_BASE = ADDR_W'(32'h4B000)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_ce,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              swap_req,
  output logic              fb_sel,
  output logic              swap_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  arb_state_t        state, nxt_state;
  logic              active;
  logic              swap_edge;
  logic              swap_pend;
  logic [ADDR_W-1:0] fb_base;
  logic [ADDR_W-1:0] disp_addr;

  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_dq_out;
  logic              nxt_ce_n, nxt_oe_n, nxt_we_n, nxt_dq_oe;

  assign active    = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE);
  assign swap_edge = pix_ce && (DrawX == 10'd0) && (DrawY == V_SWAP_LINE);
  assign fb_base   = fb_sel ? FB1_BASE : FB0_BASE;

  fb_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .base (fb_base),
    .x    (DrawX),
    .y    (DrawY),
    .addr (disp_addr)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nxt_state;
  end

  // Display always wins; a CPU op is never started right after another one,
  // which gives the requester the ack cycle to drop or change its request.
  always_comb begin
    nxt_state  = IDLE;
    nxt_addr   = sram_addr;
    nxt_dq_out = sram_dq_out;
    nxt_ce_n   = 1'b1;
    nxt_oe_n   = 1'b1;
    nxt_we_n   = 1'b1;
    nxt_dq_oe  = 1'b0;

    if (active && pix_ce)
      nxt_state = DISP_RD;
    else if (cpu_req && !is_cpu(state))
      nxt_state = cpu_we ? CPU_WR : CPU_RD;

    case (nxt_state)
      DISP_RD: begin
        nxt_addr = disp_addr;
        nxt_ce_n = 1'b0;
        nxt_oe_n = 1'b0;
      end
      CPU_RD: begin
        nxt_addr = cpu_addr;
        nxt_ce_n = 1'b0;
        nxt_oe_n = 1'b0;
      end
      CPU_WR: begin
        nxt_addr   = cpu_addr;
        nxt_dq_out = cpu_wdata;
        nxt_ce_n   = 1'b0;
        nxt_we_n   = 1'b0;
        nxt_dq_oe  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      pix_data    <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      fb_sel      <= 1'b0;
      swap_done   <= 1'b0;
      swap_pend   <= 1'b0;
    end else begin
      sram_addr   <= nxt_addr;
      sram_dq_out <= nxt_dq_out;
      sram_ce_n   <= nxt_ce_n;
      sram_oe_n   <= nxt_oe_n;
      sram_we_n   <= nxt_we_n;
      sram_dq_oe  <= nxt_dq_oe;

      // The cycle that just ended belonged to 'state'; close it out here.
      cpu_ack <= is_cpu(state);
      if (state == CPU_RD)
        cpu_rdata <= sram_dq_in;

      // pix_ce never lands on the capture edge of a display read, so these
      // two assignments do not compete in practice.
      if (pix_ce && !active)
        pix_data <= '0;
      if (state == DISP_RD)
        pix_data <= sram_dq_in;

      swap_done <= 1'b0;
      if (swap_edge && (swap_pend || swap_req)) begin
        fb_sel    <= ~fb_sel;
        swap_done <= 1'b1;
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb_vga_sram_arbiter
//   Directed bench for vga_sram_arbiter with a behavioural async SRAM.
module tb_vga_sram_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_ce;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] pix_data;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        swap_req, fb_sel, swap_done;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int n_tot = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  vga_sram_arbiter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_ce      (pix_ce),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_data    (pix_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .swap_req    (swap_req),
    .fb_sel      (fb_sel),
    .swap_done   (swap_done),
    .sram_addr   (sram_addr),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in)
  );

  // async SRAM model; preload port lets the bench seed contents
  logic [15:0] mem [0:(1<<20)-1];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  always @(posedge Clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, lat, px;
    logic req_on, just_acked, pend_pix;

    Reset_n = 1'b0; pix_ce = 1'b0; DrawX = '0; DrawY = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    swap_req = 1'b0;

    // seed memory while in reset
    preload(20'h00C87, 16'hBEEF);
    for (int x = 0; x < 20; x++) preload(20'(6400 + x), 16'(16'h1000 + x));
    for (int i = 0; i < 10; i++) preload(20'(32'h20000 + i), 16'(16'h7000 + i));
    tick(); tick(); tick();

    // 1: reset state
    chk("rst_ce_n",  32'(sram_ce_n),  32'd1);
    chk("rst_oe_n",  32'(sram_oe_n),  32'd1);
    chk("rst_we_n",  32'(sram_we_n),  32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr",  32'(sram_addr),  32'd0);
    chk("rst_pix",   32'(pix_data),   32'd0);
    chk("rst_fbsel", 32'(fb_sel),     32'd0);
    chk("rst_ack",   32'(cpu_ack),    32'd0);
    Reset_n = 1'b1;
    tick();

    // 2: display read at (7,5)
    DrawX = 10'd7; DrawY = 10'd5; pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("disp_addr", 32'(sram_addr), 32'h00C87);
    chk("disp_ce_n", 32'(sram_ce_n), 32'd0);
    chk("disp_oe_n", 32'(sram_oe_n), 32'd0);
    tick();
    chk("disp_pix",  32'(pix_data),  32'hBEEF);

    // active-area boundaries
    DrawX = 10'd640; DrawY = 10'd5; pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("hblank_pix",  32'(pix_data),  32'd0);
    chk("hblank_ce_n", 32'(sram_ce_n), 32'd1);
    DrawX = 10'd639; DrawY = 10'd479; pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("corner_addr", 32'(sram_addr), 32'h4AFFF);
    chk("corner_ce_n", 32'(sram_ce_n), 32'd0);
    tick();

    // 3: CPU write then read in vblank
    DrawX = 10'd0; DrawY = 10'd500;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h12345; cpu_wdata = 16'hA5A5;
    tick();
    chk("wr_we_n",  32'(sram_we_n),   32'd0);
    chk("wr_dq_oe", 32'(sram_dq_oe),  32'd1);
    chk("wr_addr",  32'(sram_addr),   32'h12345);
    chk("wr_dq",    32'(sram_dq_out), 32'hA5A5);
    chk("wr_oe_n",  32'(sram_oe_n),   32'd1);
    chk("wr_ack0",  32'(cpu_ack),     32'd0);
    tick();
    chk("wr_we_n_1clk", 32'(sram_we_n), 32'd1);
    chk("wr_ack1",      32'(cpu_ack),   32'd1);
    cpu_req = 1'b0;
    tick();
    chk("wr_ack_pulse", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("rd_oe_n", 32'(sram_oe_n), 32'd0);
    chk("rd_we_n", 32'(sram_we_n), 32'd1);
    tick();
    chk("rd_ack",   32'(cpu_ack),   32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5A5);
    cpu_req = 1'b0;
    tick();

    // 4: CPU reads interleaved with an active line
    DrawY = 10'd10; cpu_we = 1'b0;
    k = 0; lat = 0; px = 0;
    req_on = 1'b0; just_acked = 1'b0; pend_pix = 1'b0;
    for (int c = 0; c < 40; c++) begin
      pix_ce = (c % 2 == 0);
      DrawX  = 10'(c / 2);
      if (!req_on && !just_acked) begin
        cpu_req  = 1'b1;
        cpu_addr = 20'(32'h20000 + k);
        req_on   = 1'b1;
        lat      = 0;
      end
      tick();
      if (req_on) lat++;
      if (pend_pix) begin
        chk("line_pix", 32'(pix_data), 32'(16'h1000 + px));
        pend_pix = 1'b0;
      end
      if (pix_ce) begin
        chk("line_disp_addr", 32'(sram_addr), 32'(6400 + c / 2));
        chk("line_disp_oe",   32'(sram_oe_n), 32'd0);
        pend_pix = 1'b1;
        px = c / 2;
      end
      if (cpu_ack) begin
        chk("line_rdata", 32'(cpu_rdata), 32'(16'h7000 + k));
        chk("line_lat",   32'(lat <= 3),  32'd1);
        cpu_req    = 1'b0;
        req_on     = 1'b0;
        just_acked = 1'b1;
        k++;
      end else begin
        just_acked = 1'b0;
      end
    end
    pix_ce = 1'b0; cpu_req = 1'b0;
    chk("line_cpu_count", 32'(k), 32'd10);
    tick();

    // 5: swap requests absorbed into a single swap at (0,480)
    DrawX = 10'd50; DrawY = 10'd100; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_pend_fb", 32'(fb_sel),    32'd0);
    chk("swap_pend_sd", 32'(swap_done), 32'd0);
    DrawY = 10'd200; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_pend2_fb", 32'(fb_sel), 32'd0);
    DrawX = 10'd0; DrawY = 10'd480; pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("swap_fb",   32'(fb_sel),    32'd1);
    chk("swap_done", 32'(swap_done), 32'd1);
    chk("swap_bus",  32'(sram_ce_n), 32'd1);
    tick();
    chk("swap_done_pulse", 32'(swap_done), 32'd0);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("swap_once_fb", 32'(fb_sel),    32'd1);
    chk("swap_once_sd", 32'(swap_done), 32'd0);
    DrawX = 10'd7; DrawY = 10'd5; pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    chk("fb1_addr", 32'(sram_addr), 32'h4BC87);
    tick();
    DrawX = 10'd0; DrawY = 10'd480; pix_ce = 1'b1; swap_req = 1'b1;
    tick();
    pix_ce = 1'b0; swap_req = 1'b0;
    chk("swap_same_fb", 32'(fb_sel),    32'd0);
    chk("swap_same_sd", 32'(swap_done), 32'd1);
    tick();

    // 6: reset during a CPU read
    DrawY = 10'd500; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h12345;
    tick();
    chk("rstop_oe_n", 32'(sram_oe_n), 32'd0);
    Reset_n = 1'b0; cpu_req = 1'b0;
    tick();
    chk("rstop_ack",  32'(cpu_ack),   32'd0);
    chk("rstop_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rstop_oe_n2",32'(sram_oe_n), 32'd1);
    chk("rstop_addr", 32'(sram_addr), 32'd0);
    Reset_n = 1'b1;
    tick();
    chk("rstop_ack2", 32'(cpu_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
